// File: rtl/edge_scan_engine_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : edge_scan_pkg
//  Description : Shared types and constants for the edge scan engine.
//  Revision    : 1.0 - initial release
// ============================================================================
package edge_scan_pkg;

    localparam int COORD_W_DEF  = 10;
    localparam int STRIDE_W_DEF = 4;

    typedef logic [COORD_W_DEF-1:0] coord_t;

    typedef enum logic [1:0] {
        UP    = 2'b00,
        DOWN  = 2'b01,
        LEFT  = 2'b10,
        RIGHT = 2'b11
    } dir_e;

    typedef enum logic {
        FIRST = 1'b0,
        COUNT = 1'b1
    } mode_e;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_REQ    = 3'd2,
        S_EVAL   = 3'd3,
        S_FINISH = 3'd4
    } state_e;

    // UP/DOWN walk along rows (x is the fast axis); LEFT/RIGHT walk columns.
    function automatic logic is_row_major(input dir_e d);
        return (d == UP) || (d == DOWN);
    endfunction

endpackage
`default_nettype wire

// File: rtl/edge_scan_engine_if.sv
`default_nettype none
// ============================================================================
//  Module      : edge_scan_engine_if
//  Description : Control, result and pixel-cache signals of the scan engine.
//  Revision    : 1.0 - initial release
// ============================================================================
interface edge_scan_engine_if #(
    parameter int COORD_W  = 10,
    parameter int STRIDE_W = 4,
    parameter int CNT_W    = 2*COORD_W+1
) ();
    logic                start;
    logic                abort;
    logic [COORD_W-1:0]  win_x0;
    logic [COORD_W-1:0]  win_y0;
    logic [COORD_W-1:0]  win_x1;
    logic [COORD_W-1:0]  win_y1;
    logic [1:0]          direction;
    logic                mode;
    logic [STRIDE_W-1:0] stride;
    logic                busy;
    logic                done;
    logic                found;
    logic [COORD_W-1:0]  hit_x;
    logic [COORD_W-1:0]  hit_y;
    logic [CNT_W-1:0]    hit_count;
    logic [CNT_W-1:0]    visit_count;
    logic                bad_window;
    logic                aborted;
    logic                req;
    logic [COORD_W-1:0]  x;
    logic [COORD_W-1:0]  y;
    logic                px_ready;
    logic                pixel;

    // Controller / pixel-cache side
    modport master (
        output start, abort, win_x0, win_y0, win_x1, win_y1, direction, mode,
               stride, px_ready, pixel,
        input  busy, done, found, hit_x, hit_y, hit_count, visit_count,
               bad_window, aborted, req, x, y
    );

    // Scan engine side
    modport slave (
        input  start, abort, win_x0, win_y0, win_x1, win_y1, direction, mode,
               stride, px_ready, pixel,
        output busy, done, found, hit_x, hit_y, hit_count, visit_count,
               bad_window, aborted, req, x, y
    );
endinterface
`default_nettype wire

// File: rtl/edge_scan_engine_scan_walker.sv
`default_nettype none
// ============================================================================
//  Module      : scan_walker
//  Description : Position counters for the window scan: origin load, stride
//                advance and detection of leaving the window.
//  Revision    : 1.0 - initial release
// ============================================================================
module scan_walker
    import edge_scan_pkg::*;
#(
    parameter int COORD_W  = COORD_W_DEF,
    parameter int STRIDE_W = STRIDE_W_DEF
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                load_i,
    input  logic                step_i,
    input  logic [COORD_W-1:0]  x0_i,
    input  logic [COORD_W-1:0]  y0_i,
    input  logic [COORD_W-1:0]  x1_i,
    input  logic [COORD_W-1:0]  y1_i,
    input  dir_e                dir_i,
    input  logic [STRIDE_W-1:0] stride_i,
    output logic [COORD_W-1:0]  x_o,
    output logic [COORD_W-1:0]  y_o,
    output logic                leave_o
);
    // One spare bit so that 0-1 and max+stride land outside the window
    localparam int PW = COORD_W + 1;

    logic [PW-1:0] x_q, y_q, x_d, y_d;
    logic [PW-1:0] w_x0, w_y0, w_x1, w_y1, w_stride;
    logic [PW-1:0] w_x_org, w_y_org, w_x_adv, w_y_adv;

    assign w_x0     = {1'b0, x0_i};
    assign w_y0     = {1'b0, y0_i};
    assign w_x1     = {1'b0, x1_i};
    assign w_y1     = {1'b0, y1_i};
    assign w_stride = {{(PW-STRIDE_W){1'b0}}, stride_i};

    // Scan origin and next position along the fast / slow axes
    always_comb begin
        w_x_org = (dir_i == LEFT) ? w_x1 : w_x0;
        w_y_org = (dir_i == UP)   ? w_y1 : w_y0;
        w_x_adv = x_q + w_stride;
        w_y_adv = y_q + w_stride;
        x_d     = x_q;
        y_d     = y_q;
        if (is_row_major(dir_i)) begin
            if (w_x_adv > w_x1) begin
                x_d = w_x0;
                y_d = (dir_i == UP) ? (y_q - PW'(1)) : (y_q + PW'(1));
            end else begin
                x_d = w_x_adv;
            end
        end else begin
            if (w_y_adv > w_y1) begin
                y_d = w_y0;
                x_d = (dir_i == RIGHT) ? (x_q + PW'(1)) : (x_q - PW'(1));
            end else begin
                y_d = w_y_adv;
            end
        end
        leave_o = (x_d < w_x0) || (x_d > w_x1) || (y_d < w_y0) || (y_d > w_y1);
    end

    // Position register: origin on load, advance on step
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_q <= '0;
            y_q <= '0;
        end else if (load_i) begin
            x_q <= w_x_org;
            y_q <= w_y_org;
        end else if (step_i) begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x_o = x_q[COORD_W-1:0];
    assign y_o = y_q[COORD_W-1:0];

endmodule
`default_nettype wire

// File: rtl/edge_scan_engine.sv
`default_nettype none
// ============================================================================
//  Module      : edge_scan_engine
//  Description : Rectangular-window edge search; FIRST-hit or COUNT mode,
//                four scan directions, pixels read over a req/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module edge_scan_engine
    import edge_scan_pkg::*;
#(
    parameter int COORD_W  = COORD_W_DEF,
    parameter int STRIDE_W = STRIDE_W_DEF,
    parameter int CNT_W    = 2*COORD_W+1
) (
    input  logic              clk,
    input  logic              reset_n,
    edge_scan_engine_if.slave bus
);
    state_e              state_q, state_d;
    logic [COORD_W-1:0]  x0_q, y0_q, x1_q, y1_q;
    dir_e                dir_q;
    mode_e               mode_q;
    logic [STRIDE_W-1:0] stride_q;
    logic                pix_q, found_q, bad_q, aborted_q;
    logic [COORD_W-1:0]  hit_x_q, hit_y_q;
    logic [CNT_W-1:0]    hit_cnt_q, vis_cnt_q;

    logic w_busy, w_done, w_req, w_load, w_step;
    logic w_accept, w_abort, w_bad, w_leave, w_stop;
    logic [COORD_W-1:0] w_x, w_y;

    assign w_accept = bus.start && ((state_q == S_IDLE) || (state_q == S_FINISH));
    assign w_abort  = bus.abort && w_busy;
    assign w_bad    = (x0_q > x1_q) || (y0_q > y1_q);
    assign w_stop   = ((mode_q == FIRST) && pix_q) || w_leave;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic; abort takes priority in every busy state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_FINISH: if (bus.start) state_d = S_LOAD;
            S_LOAD:           state_d = (bus.abort || w_bad) ? S_FINISH : S_REQ;
            S_REQ: begin
                if (bus.abort)         state_d = S_FINISH;
                else if (bus.px_ready) state_d = S_EVAL;
            end
            S_EVAL:           state_d = (bus.abort || w_stop) ? S_FINISH : S_REQ;
            default:          state_d = S_IDLE;
        endcase
    end

    // State-decoded outputs and walker strobes
    always_comb begin
        w_busy = (state_q == S_LOAD) || (state_q == S_REQ) || (state_q == S_EVAL);
        w_done = (state_q == S_FINISH);
        w_req  = (state_q == S_REQ);
        w_load = (state_q == S_LOAD);
        w_step = (state_q == S_EVAL) && (state_d == S_REQ);
    end

    // Config latch, pixel capture and result accumulation
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x0_q <= '0; y0_q <= '0; x1_q <= '0; y1_q <= '0;
            dir_q <= UP; mode_q <= FIRST; stride_q <= '0;
            pix_q <= 1'b0; found_q <= 1'b0; bad_q <= 1'b0; aborted_q <= 1'b0;
            hit_x_q <= '0; hit_y_q <= '0; hit_cnt_q <= '0; vis_cnt_q <= '0;
        end else if (w_accept) begin
            x0_q      <= bus.win_x0;
            y0_q      <= bus.win_y0;
            x1_q      <= bus.win_x1;
            y1_q      <= bus.win_y1;
            dir_q     <= dir_e'(bus.direction);
            mode_q    <= mode_e'(bus.mode);
            stride_q  <= (bus.stride == '0) ? STRIDE_W'(1) : bus.stride;
            found_q   <= 1'b0;
            bad_q     <= 1'b0;
            aborted_q <= 1'b0;
            hit_x_q   <= '0;
            hit_y_q   <= '0;
            hit_cnt_q <= '0;
            vis_cnt_q <= '0;
        end else begin
            if (w_load)   bad_q     <= w_bad;
            if (w_abort)  aborted_q <= 1'b1;
            if (w_req && bus.px_ready) pix_q <= bus.pixel;
            // The pixel in EVAL has been read, so it is counted even on abort
            if (state_q == S_EVAL) begin
                vis_cnt_q <= vis_cnt_q + CNT_W'(1);
                if (pix_q) begin
                    hit_cnt_q <= hit_cnt_q + CNT_W'(1);
                    found_q   <= 1'b1;
                    if (!found_q) begin
                        hit_x_q <= w_x;
                        hit_y_q <= w_y;
                    end
                end
            end
        end
    end

    scan_walker #(
        .COORD_W  (COORD_W),
        .STRIDE_W (STRIDE_W)
    ) u_walker (
        .clk      (clk),
        .reset_n  (reset_n),
        .load_i   (w_load),
        .step_i   (w_step),
        .x0_i     (x0_q),
        .y0_i     (y0_q),
        .x1_i     (x1_q),
        .y1_i     (y1_q),
        .dir_i    (dir_q),
        .stride_i (stride_q),
        .x_o      (w_x),
        .y_o      (w_y),
        .leave_o  (w_leave)
    );

    assign bus.busy        = w_busy;
    assign bus.done        = w_done;
    assign bus.req         = w_req;
    assign bus.x           = w_x;
    assign bus.y           = w_y;
    assign bus.found       = found_q;
    assign bus.hit_x       = hit_x_q;
    assign bus.hit_y       = hit_y_q;
    assign bus.hit_count   = hit_cnt_q;
    assign bus.visit_count = vis_cnt_q;
    assign bus.bad_window  = bad_q;
    assign bus.aborted     = aborted_q;

endmodule
`default_nettype wire

// File: tb/tb_edge_scan_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_edge_scan_engine
//  Description : Self-checking bench for edge_scan_engine with a pixel-cache
//                model and a loop-based reference model of the scan order.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_edge_scan_engine;
    localparam int CW     = 10;
    localparam int SW     = 4;
    localparam int NW     = 2*CW+1;
    localparam int BUDGET = 20000;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    edge_scan_engine_if #(.COORD_W(CW), .STRIDE_W(SW), .CNT_W(NW)) bus ();

    edge_scan_engine #(.COORD_W(CW), .STRIDE_W(SW), .CNT_W(NW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    int cache_lat = 1;
    bit img [0:31][0:31];

    function automatic bit img_at(input int x, input int y);
        if (x < 32 && y < 32) return img[y][x];
        return ((x + y) % 3) == 0;
    endfunction

    // Pixel cache: answers a request after cache_lat sampled cycles
    initial begin
        int wait_cnt;
        wait_cnt = 0;
        bus.px_ready = 1'b0;
        bus.pixel    = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.px_ready) begin
                bus.px_ready = 1'b0;
                bus.pixel    = 1'b0;
                wait_cnt     = 0;
            end else if (bus.req) begin
                if (wait_cnt >= cache_lat) begin
                    bus.px_ready = 1'b1;
                    bus.pixel    = img_at(int'(bus.x), int'(bus.y));
                    wait_cnt     = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: walk the window with nested loops in scan order
    function automatic void model(input int x0, y0, x1, y1, dir, mode, stride,
                                  output int f, hx, hy, hc, vc, bad);
        int s, xx, yy;
        bit stop;
        f = 0; hx = 0; hy = 0; hc = 0; vc = 0; stop = 0;
        s   = (stride == 0) ? 1 : stride;
        bad = (x0 > x1 || y0 > y1) ? 1 : 0;
        if (bad != 0) return;
        if (dir < 2) begin
            for (int r = 0; r <= y1 - y0 && !stop; r++) begin
                yy = (dir == 1) ? y0 + r : y1 - r;
                for (xx = x0; xx <= x1 && !stop; xx += s) begin
                    vc++;
                    if (img_at(xx, yy)) begin
                        if (f == 0) begin hx = xx; hy = yy; end
                        f = 1; hc++;
                        if (mode == 0) stop = 1;
                    end
                end
            end
        end else begin
            for (int c = 0; c <= x1 - x0 && !stop; c++) begin
                xx = (dir == 3) ? x0 + c : x1 - c;
                for (yy = y0; yy <= y1 && !stop; yy += s) begin
                    vc++;
                    if (img_at(xx, yy)) begin
                        if (f == 0) begin hx = xx; hy = yy; end
                        f = 1; hc++;
                        if (mode == 0) stop = 1;
                    end
                end
            end
        end
    endfunction

    task automatic start_scan(input int x0, y0, x1, y1, dir, mode, stride, input bit with_abort);
        @(posedge clk);
        #1;
        bus.win_x0    = CW'(x0);
        bus.win_y0    = CW'(y0);
        bus.win_x1    = CW'(x1);
        bus.win_y1    = CW'(y1);
        bus.direction = 2'(dir);
        bus.mode      = 1'(mode);
        bus.stride    = SW'(stride);
        bus.abort     = with_abort;
        bus.start     = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
    endtask

    task automatic check_result(input string name, input int x0, y0, x1, y1, dir, mode, stride);
        int ef, ehx, ehy, ehc, evc, eb, n;
        bit req_seen;
        model(x0, y0, x1, y1, dir, mode, stride, ef, ehx, ehy, ehc, evc, eb);
        n = 0;
        req_seen = 0;
        while (bus.done !== 1'b1 && n < BUDGET) begin
            @(negedge clk);
            n++;
            if (bus.req === 1'b1) req_seen = 1;
        end
        chk({name, " done"},        32'(bus.done), 1);
        chk({name, " busy"},        32'(bus.busy), 0);
        chk({name, " bad_window"},  32'(bus.bad_window), 32'(eb));
        chk({name, " aborted"},     32'(bus.aborted), 0);
        chk({name, " found"},       32'(bus.found), 32'(ef));
        chk({name, " hit_count"},   32'(bus.hit_count), 32'(ehc));
        chk({name, " visit_count"}, 32'(bus.visit_count), 32'(evc));
        if (ef != 0) begin
            chk({name, " hit_x"}, 32'(bus.hit_x), 32'(ehx));
            chk({name, " hit_y"}, 32'(bus.hit_y), 32'(ehy));
        end
        if (eb != 0) chk({name, " req_seen"}, 32'(req_seen), 0);
    endtask

    task automatic run_scan(input string name, input int x0, y0, x1, y1, dir, mode, stride);
        start_scan(x0, y0, x1, y1, dir, mode, stride, 1'b0);
        check_result(name, x0, y0, x1, y1, dir, mode, stride);
    endtask

    initial begin
        int rises, n, x0, y0, x1, y1, tmp;
        bit prev;
        bus.start = 0; bus.abort = 0; bus.win_x0 = 0; bus.win_y0 = 0;
        bus.win_x1 = 0; bus.win_y1 = 0; bus.direction = 0; bus.mode = 0; bus.stride = 0;
        for (int yy = 0; yy < 32; yy++)
            for (int xx = 0; xx < 32; xx++) img[yy][xx] = 1'b0;
        img[2][7] = 1'b1; img[3][3] = 1'b1; img[4][9] = 1'b1; img[5][5] = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst busy", 32'(bus.busy), 0);
        chk("rst done", 32'(bus.done), 0);
        chk("rst req",  32'(bus.req), 0);
        chk("rst x",    32'(bus.x), 0);
        chk("rst y",    32'(bus.y), 0);
        @(posedge clk); #1 reset_n = 1'b1;

        // DOWN FIRST, with start-to-req latency
        start_scan(0, 0, 9, 9, 1, 0, 1, 1'b0);
        @(negedge clk);
        chk("lat busy c1", 32'(bus.busy), 1);
        chk("lat req c1",  32'(bus.req), 0);
        @(negedge clk);
        chk("lat req c2",  32'(bus.req), 1);
        check_result("down", 0, 0, 9, 9, 1, 0, 1);
        chk("down visits const", 32'(bus.visit_count), 28);

        run_scan("up", 0, 0, 9, 9, 0, 0, 1);
        chk("up visits const", 32'(bus.visit_count), 46);
        run_scan("right", 0, 0, 9, 9, 3, 0, 1);
        chk("right visits const", 32'(bus.visit_count), 34);
        run_scan("left", 0, 0, 9, 9, 2, 0, 1);
        chk("left visits const", 32'(bus.visit_count), 5);
        run_scan("count", 0, 0, 9, 9, 1, 1, 1);
        chk("count hits const", 32'(bus.hit_count), 4);
        run_scan("stride2", 0, 0, 9, 9, 1, 0, 2);
        chk("stride2 visits const", 32'(bus.visit_count), 50);
        run_scan("badwin", 5, 0, 4, 9, 1, 0, 1);
        chk("badwin visits const", 32'(bus.visit_count), 0);

        // Abort when not busy is ignored
        @(posedge clk); #1 bus.abort = 1'b1;
        @(posedge clk); #1 bus.abort = 1'b0;
        @(negedge clk);
        chk("idle abort aborted", 32'(bus.aborted), 0);
        chk("idle abort done",    32'(bus.done), 1);

        // Start while busy is ignored
        start_scan(0, 0, 9, 9, 1, 0, 1, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        bus.direction = 2'd2; bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
        check_result("busy start", 0, 0, 9, 9, 1, 0, 1);

        // Abort while in REQ of a COUNT scan, on the 14th request
        start_scan(0, 0, 9, 9, 1, 1, 1, 1'b0);
        rises = 0; prev = 0; n = 0;
        while (rises < 14 && n < BUDGET) begin
            @(negedge clk);
            n++;
            if (bus.req === 1'b1 && !prev) rises++;
            prev = (bus.req === 1'b1);
        end
        chk("abort reach", 32'(rises), 14);
        bus.abort = 1'b1;
        @(posedge clk); #1 bus.abort = 1'b0;
        @(negedge clk);
        chk("abort req",     32'(bus.req), 0);
        chk("abort aborted", 32'(bus.aborted), 1);
        chk("abort done",    32'(bus.done), 1);
        chk("abort busy",    32'(bus.busy), 0);
        chk("abort visits",  32'(bus.visit_count), 13);
        chk("abort hits",    32'(bus.hit_count), 0);

        // Start and abort together while not busy: start wins
        start_scan(0, 0, 9, 9, 0, 0, 1, 1'b1);
        check_result("restart", 0, 0, 9, 9, 0, 0, 1);

        // Boundary windows: coordinate 0 and coordinate max, all directions
        for (int d = 0; d < 4; d++) begin
            run_scan("edge0", 0, 0, 9, 9, d, 1, 3);
            cache_lat = d % 3;
            run_scan("edgemax", 1019, 1020, 1023, 1023, d, 1, 2);
        end

        // Randomized windows, image, direction, mode, stride and cache latency
        for (int t = 0; t < 20; t++) begin
            for (int yy = 0; yy < 32; yy++)
                for (int xx = 0; xx < 32; xx++) img[yy][xx] = ($urandom_range(0, 9) == 0);
            x0 = $urandom_range(0, 15); x1 = x0 + $urandom_range(0, 12);
            y0 = $urandom_range(0, 15); y1 = y0 + $urandom_range(0, 12);
            if ($urandom_range(0, 7) == 0) begin tmp = x0; x0 = x1 + 1; x1 = tmp; end
            cache_lat = $urandom_range(0, 2);
            run_scan("rand", x0, y0, x1, y1, $urandom_range(0, 3), $urandom_range(0, 1),
                     $urandom_range(0, 15));
        end

        // Reset mid-scan clears outputs asynchronously
        cache_lat = 1;
        start_scan(0, 0, 20, 20, 1, 1, 1, 1'b0);
        n = 0;
        while (n < 40 || bus.req !== 1'b1) begin
            @(negedge clk);
            n++;
            if (n > BUDGET) break;
        end
        reset_n = 1'b0;
        #1;
        chk("midrst req",    32'(bus.req), 0);
        chk("midrst busy",   32'(bus.busy), 0);
        chk("midrst x",      32'(bus.x), 0);
        chk("midrst y",      32'(bus.y), 0);
        chk("midrst visits", 32'(bus.visit_count), 0);
        chk("midrst found",  32'(bus.found), 0);
        @(posedge clk); #1 reset_n = 1'b1;
        run_scan("post reset", 2, 3, 8, 6, 3, 1, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
